// File: rtl/tgmux_phase_ctrl.sv
// Break-before-make phase controller for the CKN/CKP gate pairs of an N-input transmission-gate mux.
// Accepts select requests on valid/ready, opens all gates, makes the new one, waits for settling, pulses done.
module tgmux_phase_ctrl #(
   parameter int N_CH       = 4,
   parameter int SEL_W      = 2,
   parameter int DEAD_CYC   = 2,
   parameter int SETTLE_CYC = 3,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_en,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   output logic [N_CH-1:0]  ckn,
   output logic [N_CH-1:0]  ckp,
   output logic [SEL_W-1:0] cur_sel,
   output logic             cur_en,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DEAD   = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [SEL_W:0] N_CH_L        = (SEL_W+1)'(N_CH);
   localparam logic [CNT_W-1:0] DEAD_INIT   = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             tgt_en_r;
   logic [SEL_W-1:0] tgt_sel_r;
   logic [N_CH-1:0]  ckn_r;
   logic [N_CH-1:0]  ckp_r;
   logic [SEL_W-1:0] cur_sel_r;
   logic             cur_en_r;
   logic             busy_r;
   logic             done_r;
   logic             ready_r;

   logic             in_range_s;
   logic             req_en_s;
   logic             same_s;
   logic             accept_s;

   function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
      onehot = {{(N_CH-1){1'b0}}, 1'b1} << sel;
   endfunction

   // Out-of-range selects collapse to a disconnect request.
   assign in_range_s = ({1'b0, req_sel} < N_CH_L);
   assign req_en_s   = req_en & in_range_s;
   // A disconnect while already disconnected matches regardless of the stale select value.
   assign same_s     = (req_en_s == cur_en_r) && (!req_en_s || (req_sel == cur_sel_r));
   assign accept_s   = req_valid & ready_r;

   // Sequencer: state, counter, captured target and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         tgt_en_r  <= 1'b0;
         tgt_sel_r <= {SEL_W{1'b0}};
         ckn_r     <= {N_CH{1'b0}};
         ckp_r     <= {N_CH{1'b1}};
         cur_sel_r <= {SEL_W{1'b0}};
         cur_en_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  tgt_en_r  <= req_en_s;
                  tgt_sel_r <= req_sel;
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
                  if (same_s) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end else begin
                     ckn_r    <= {N_CH{1'b0}};
                     ckp_r    <= {N_CH{1'b1}};
                     cur_en_r <= 1'b0;
                     cnt_r    <= DEAD_INIT;
                     state_r  <= DEAD;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            DEAD: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end else if (tgt_en_r) begin
                  ckn_r     <= onehot(tgt_sel_r);
                  ckp_r     <= ~onehot(tgt_sel_r);
                  cur_sel_r <= tgt_sel_r;
                  cur_en_r  <= 1'b1;
                  cnt_r     <= SETTLE_INIT;
                  state_r   <= SETTLE;
               end else begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            SETTLE: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end else begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               state_r  <= IDLE;
               ckn_r    <= {N_CH{1'b0}};
               ckp_r    <= {N_CH{1'b1}};
               cur_en_r <= 1'b0;
               busy_r   <= 1'b0;
               ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready = ready_r;
   assign ckn       = ckn_r;
   assign ckp       = ckp_r;
   assign cur_sel   = cur_sel_r;
   assign cur_en    = cur_en_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule
